// File: rtl/swerv_types_pkg.sv
// swerv_types_pkg: shared trigger packet, stored mcontrol fields and tdata1 read packing
package swerv_types_pkg;
  localparam logic [3:0] MCTRL_TYPE = 4'h2;
  localparam logic [5:0] MCTRL_MASKMAX = 6'd31;
  typedef struct packed {
    logic select;
    logic match;
    logic store;
    logic load;
    logic execute;
    logic m;
    logic [31:0] tdata2;
  } trigger_pkt_t;
  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } mcontrol_t;
  function automatic logic [31:0] mctrl_pack(mcontrol_t c);
    return {MCTRL_TYPE, c.dmode, MCTRL_MASKMAX, c.hit, c.select, 1'b0, 2'b0,
            3'b0, c.action, c.chain, 3'b0, c.match, c.m, 3'b0, c.execute, c.store, c.load};
  endfunction
endpackage

// File: rtl/dec_trigger_csr_if.sv
// dec_trigger_csr_if: CSR write/read bus for the trigger CSR block
interface dec_trigger_csr_if;
  logic csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic csr_rd_hit;
  modport master(output csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr, input csr_rd_data, csr_rd_hit);
  modport slave(input csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr, output csr_rd_data, csr_rd_hit);
endinterface

// File: rtl/dec_trigger_chain.sv
// dec_trigger_chain: combinational chaining of one even/odd trigger pair
module dec_trigger_chain (
  input  logic [1:0] raw,
  input  logic       chain,
  output logic [1:0] fire
);
  always_comb fire = chain ? {2{&raw}} : raw;
endmodule

// File: rtl/dec_trigger_csr.sv
// dec_trigger_csr: debug trigger CSRs, match qualification, chaining and fire/action reporting
module dec_trigger_csr
  import swerv_types_pkg::*;
#(
  parameter int NUM_TRIG = 4,
  parameter logic [11:0] TSEL_ADDR = 12'h7A0
) (
  input  logic clk,
  input  logic rst_l,
  dec_trigger_csr_if.slave bus,
  input  logic dbg_mode,
  input  logic flush,
  input  logic [NUM_TRIG-1:0] lsu_match,
  input  logic [NUM_TRIG-1:0] ifu_match,
  output trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
  output logic [NUM_TRIG-1:0] trig_fire,
  output logic trig_act_dbg,
  output logic trig_act_bkpt
);
  localparam logic [11:0] TD1_ADDR = TSEL_ADDR + 12'd1;
  localparam logic [11:0] TD2_ADDR = TSEL_ADDR + 12'd2;
  logic [1:0] tsel, tsel_n;
  mcontrol_t [NUM_TRIG-1:0] mc, mc_n;
  logic [NUM_TRIG-1:0][31:0] tdata2, tdata2_n;
  logic [NUM_TRIG-1:0] raw, fire_n, act_v, dm_v;
  logic wr0, wr1, wr2;
  logic [31:0] d;
  assign d = bus.csr_wr_data;
  assign wr0 = bus.csr_wr_en && bus.csr_wr_addr == TSEL_ADDR;
  assign wr1 = bus.csr_wr_en && bus.csr_wr_addr == TD1_ADDR;
  assign wr2 = bus.csr_wr_en && bus.csr_wr_addr == TD2_ADDR;
  assign raw = (lsu_match | ifu_match) & {NUM_TRIG{~flush & ~dbg_mode}};
  for (genvar g = 0; g < NUM_TRIG / 2; g++) begin : g_pair
    dec_trigger_chain u_chain (
      .raw  (raw[2*g+:2]),
      .chain(mc[2*g].chain),
      .fire (fire_n[2*g+:2])
    );
  end
  always_comb begin
    bus.csr_rd_hit = bus.csr_rd_addr == TSEL_ADDR || bus.csr_rd_addr == TD1_ADDR || bus.csr_rd_addr == TD2_ADDR;
    bus.csr_rd_data = bus.csr_rd_addr == TSEL_ADDR ? {30'b0, tsel} :
                      bus.csr_rd_addr == TD1_ADDR  ? mctrl_pack(mc[tsel]) :
                      bus.csr_rd_addr == TD2_ADDR  ? tdata2[tsel] : 32'b0;
  end
  always_comb begin
    for (int i = 0; i < NUM_TRIG; i++) begin
      trigger_pkt_any[i].select = mc[i].select;
      trigger_pkt_any[i].match = mc[i].match;
      trigger_pkt_any[i].store = mc[i].store & mc[i].m & ~dbg_mode;
      trigger_pkt_any[i].load = mc[i].load & mc[i].m & ~dbg_mode;
      trigger_pkt_any[i].execute = mc[i].execute & mc[i].m & ~dbg_mode;
      trigger_pkt_any[i].m = mc[i].m;
      trigger_pkt_any[i].tdata2 = tdata2[i];
      act_v[i] = mc[i].action;
      dm_v[i] = mc[i].dmode;
    end
  end
  always_comb begin
    tsel_n = (wr0 && d < NUM_TRIG) ? d[1:0] : tsel;
    mc_n = mc;
    tdata2_n = tdata2;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (tsel == 2'(i) && (!mc[i].dmode || dbg_mode)) begin
        if (wr1) begin
          mc_n[i].dmode = dbg_mode ? d[27] : mc[i].dmode;
          mc_n[i].hit = d[20];
          mc_n[i].select = d[19];
          mc_n[i].action = d[15:13] == 3'b0 && d[12];
          mc_n[i].chain = (i % 2 == 0) && (!mc[i|1].dmode || dbg_mode) ? d[11] : mc[i].chain;
          mc_n[i].match = d[10:8] == 3'b0 && d[7];
          mc_n[i].m = d[6];
          mc_n[i].execute = d[2];
          mc_n[i].store = d[1];
          mc_n[i].load = d[0];
        end
        if (wr2) tdata2_n[i] = d;
      end
      mc_n[i].hit = mc_n[i].hit | fire_n[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      tsel <= '0;
      mc <= '0;
      tdata2 <= '0;
      trig_fire <= '0;
      trig_act_dbg <= 1'b0;
      trig_act_bkpt <= 1'b0;
    end else begin
      tsel <= tsel_n;
      mc <= mc_n;
      tdata2 <= tdata2_n;
      trig_fire <= fire_n;
      trig_act_dbg <= |(fire_n & act_v & dm_v);
      trig_act_bkpt <= |(fire_n & ~(act_v & dm_v));
    end
  end
endmodule

// File: tb/tb_dec_trigger_csr.sv
// tb_dec_trigger_csr: scoreboard-driven checks of trigger CSRs, chaining and actions
module tb_dec_trigger_csr;
  import swerv_types_pkg::*;
  typedef struct packed {
    logic [3:0] fire;
    logic dbg;
    logic bkpt;
  } exp_t;
  logic clk, rst_l, dbg_mode, flush;
  logic [3:0] lsu_match, ifu_match, trig_fire;
  trigger_pkt_t [3:0] trigger_pkt_any;
  logic trig_act_dbg, trig_act_bkpt;
  exp_t sbq[$];
  exp_t e, g;
  int tests, fails;
  logic [31:0] r;
  dec_trigger_csr_if bus ();
  dec_trigger_csr dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus),
    .dbg_mode(dbg_mode),
    .flush(flush),
    .lsu_match(lsu_match),
    .ifu_match(ifu_match),
    .trigger_pkt_any(trigger_pkt_any),
    .trig_fire(trig_fire),
    .trig_act_dbg(trig_act_dbg),
    .trig_act_bkpt(trig_act_bkpt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic wr(input logic [11:0] a, input logic [31:0] dat);
    bus.csr_wr_en = 1'b1;
    bus.csr_wr_addr = a;
    bus.csr_wr_data = dat;
    @(posedge clk);
    #1;
    bus.csr_wr_en = 1'b0;
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] dat);
    bus.csr_rd_addr = a;
    #1;
    dat = bus.csr_rd_data;
  endtask
  task automatic drive(input logic [3:0] l, input logic [3:0] f, input exp_t x);
    lsu_match = l;
    ifu_match = f;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    lsu_match = 4'b0;
    ifu_match = 4'b0;
  endtask
  task automatic test_reset;
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23E0_0000) begin fails++; $display("FAIL reset_tdata1 got=%h exp=%h", r, 32'h23E0_0000); end
    tests++;
    if (bus.csr_rd_hit !== 1'b1) begin fails++; $display("FAIL reset_rdhit got=%b exp=1", bus.csr_rd_hit); end
    rd(12'h7A0, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL reset_tsel got=%h exp=0", r); end
    rd(12'h7A3, r);
    tests++;
    if (r !== 32'h0 || bus.csr_rd_hit !== 1'b0) begin fails++; $display("FAIL nohit_read got=%h/%b exp=0/0", r, bus.csr_rd_hit); end
    tests++;
    if (trigger_pkt_any !== '0 || trig_fire !== 4'b0 || trig_act_dbg !== 1'b0 || trig_act_bkpt !== 1'b0) begin
      fails++; $display("FAIL reset_outputs got=%h/%b exp=0/0", trigger_pkt_any, trig_fire);
    end
  endtask
  task automatic test_basic_fire;
    trigger_pkt_t ep;
    wr(12'h7A0, 32'd1);
    wr(12'h7A2, 32'h8000_1000);
    wr(12'h7A1, 32'h2000_0043);
    rd(12'h7A2, r);
    tests++;
    if (r !== 32'h8000_1000) begin fails++; $display("FAIL tdata2_rd got=%h exp=%h", r, 32'h8000_1000); end
    ep = '{select: 1'b0, match: 1'b0, store: 1'b1, load: 1'b1, execute: 1'b0, m: 1'b1, tdata2: 32'h8000_1000};
    tests++;
    if (trigger_pkt_any[1] !== ep) begin fails++; $display("FAIL pkt1 got=%h exp=%h", trigger_pkt_any[1], ep); end
    drive(4'b0010, 4'b0, '{fire: 4'b0010, dbg: 1'b0, bkpt: 1'b1});
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL basic_fire got=%h exp=%h", g, e); end
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23F0_0043) begin fails++; $display("FAIL basic_hit got=%h exp=%h", r, 32'h23F0_0043); end
    @(posedge clk);
    #1;
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== 6'b0) begin fails++; $display("FAIL act_pulse got=%h exp=0", g); end
  endtask
  task automatic test_dbg_pkt;
    dbg_mode = 1'b1;
    #1;
    tests++;
    if (trigger_pkt_any[1].store !== 1'b0 || trigger_pkt_any[1].load !== 1'b0) begin
      fails++; $display("FAIL dbg_pkt got=%b%b exp=00", trigger_pkt_any[1].store, trigger_pkt_any[1].load);
    end
    drive(4'b0010, 4'b0, '{fire: 4'b0, dbg: 1'b0, bkpt: 1'b0});
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL dbg_nofire got=%h exp=%h", g, e); end
    dbg_mode = 1'b0;
  endtask
  task automatic test_chain;
    wr(12'h7A0, 32'd0);
    wr(12'h7A1, 32'h2000_0842);
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23E0_0842) begin fails++; $display("FAIL chain_rd got=%h exp=%h", r, 32'h23E0_0842); end
    drive(4'b0001, 4'b0, '{fire: 4'b0, dbg: 1'b0, bkpt: 1'b0});
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL chain_half got=%h exp=%h", g, e); end
    drive(4'b0011, 4'b0, '{fire: 4'b0011, dbg: 1'b0, bkpt: 1'b1});
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL chain_both got=%h exp=%h", g, e); end
  endtask
  task automatic test_dmode_lock;
    dbg_mode = 1'b1;
    wr(12'h7A0, 32'd2);
    wr(12'h7A1, 32'h2800_1044);
    dbg_mode = 1'b0;
    wr(12'h7A1, 32'h0);
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h2BE0_1044) begin fails++; $display("FAIL dmode_lock got=%h exp=%h", r, 32'h2BE0_1044); end
    drive(4'b0, 4'b0100, '{fire: 4'b0100, dbg: 1'b1, bkpt: 1'b0});
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL dmode_act got=%h exp=%h", g, e); end
  endtask
  task automatic test_tsel_action;
    wr(12'h7A0, 32'd1);
    wr(12'h7A0, 32'd5);
    rd(12'h7A0, r);
    tests++;
    if (r !== 32'd1) begin fails++; $display("FAIL tsel_keep got=%h exp=1", r); end
    wr(12'h7A1, 32'h2000_3043);
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23E0_0043) begin fails++; $display("FAIL action_legal got=%h exp=%h", r, 32'h23E0_0043); end
  endtask
  task automatic test_flush;
    flush = 1'b1;
    drive(4'hF, 4'b0, '{fire: 4'b0, dbg: 1'b0, bkpt: 1'b0});
    flush = 1'b0;
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL flush_fire got=%h exp=%h", g, e); end
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23E0_0043) begin fails++; $display("FAIL flush_hit1 got=%h exp=%h", r, 32'h23E0_0043); end
    wr(12'h7A0, 32'd0);
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23F0_0842) begin fails++; $display("FAIL flush_hit0 got=%h exp=%h", r, 32'h23F0_0842); end
  endtask
  task automatic test_back_to_back;
    wr(12'h7A0, 32'd1);
    bus.csr_wr_en = 1'b1;
    bus.csr_wr_addr = 12'h7A1;
    bus.csr_wr_data = 32'h2000_0043;
    drive(4'b0011, 4'b0, '{fire: 4'b0011, dbg: 1'b0, bkpt: 1'b1});
    bus.csr_wr_en = 1'b0;
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL same_cycle_fire got=%h exp=%h", g, e); end
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23F0_0043) begin fails++; $display("FAIL same_cycle_hit got=%h exp=%h", r, 32'h23F0_0043); end
  endtask
  task automatic test_reset_mid;
    rst_l = 1'b0;
    drive(4'b0011, 4'b0, '{fire: 4'b0, dbg: 1'b0, bkpt: 1'b0});
    rst_l = 1'b1;
    e = sbq.pop_front();
    g = {trig_fire, trig_act_dbg, trig_act_bkpt};
    tests++;
    if (g !== e) begin fails++; $display("FAIL midreset_fire got=%h exp=%h", g, e); end
    rd(12'h7A0, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL midreset_tsel got=%h exp=0", r); end
    rd(12'h7A1, r);
    tests++;
    if (r !== 32'h23E0_0000) begin fails++; $display("FAIL midreset_tdata1 got=%h exp=%h", r, 32'h23E0_0000); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst_l = 1'b0;
    dbg_mode = 1'b0;
    flush = 1'b0;
    lsu_match = 4'b0;
    ifu_match = 4'b0;
    bus.csr_wr_en = 1'b0;
    bus.csr_wr_addr = 12'h0;
    bus.csr_wr_data = 32'h0;
    bus.csr_rd_addr = 12'h0;
    test_reset;
    test_basic_fire;
    test_dbg_pkt;
    test_chain;
    test_dmode_lock;
    test_tsel_action;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
